// File: rtl/custom_adder_pkg.sv
// Shared defaults and chunk-geometry helpers for the pipelined custom adder.
package custom_adder_pkg;

  localparam int DEF_WA     = 41;
  localparam int DEF_WB     = 21;
  localparam int DEF_STAGES = 3;

  function automatic int chunk_w(input int wa, input int stages);
    return (wa + stages - 1) / stages;
  endfunction

  function automatic int chunk_lo(input int k, input int wa, input int stages);
    return k * chunk_w(wa, stages);
  endfunction

  // The last chunk is clipped to the operand width, so it may be narrower.
  function automatic int chunk_hi(input int k, input int wa, input int stages);
    int top;
    top = (k + 1) * chunk_w(wa, stages);
    return ((top < wa) ? top : wa) - 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit slice of the split carry chain: s + cout = a + b + cin.
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/pipelined_custom_adder.sv
// WA + WB adder whose carry chain is cut into STAGES registered chunks with valid/ready flow control.
// Define PIPELINED_CUSTOM_ADDER_SIGNED_EN for a two's-complement build (B sign-extended, sum[WA] = sign).
module pipelined_custom_adder
  import custom_adder_pkg::*;
#(
  parameter int WA     = DEF_WA,
  parameter int WB     = DEF_WB,
  parameter int STAGES = DEF_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA:0]   sum
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  function automatic logic [WA-1:0] ext_b(input logic [WB-1:0] v);
`ifdef PIPELINED_CUSTOM_ADDER_SIGNED_EN
    logic signed [WB-1:0] sv;
    sv = v;
    return WA'(sv);
`else
    return WA'(v);
`endif
  endfunction

  // Backpressure ripples from the output toward the input; an empty stage always loads.
  always_comb begin
    adv        = '0;
    load       = '0;
    adv[LAST]  = vld[LAST] && out_ready;
    load[LAST] = !vld[LAST] || adv[LAST];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k]  = vld[k] && load[k+1];
      load[k] = !vld[k] || adv[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = chunk_lo(k, WA, STAGES);
    localparam int HI = chunk_hi(k, WA, STAGES);
    localparam int W  = HI - LO + 1;
    localparam int RW = WA - LO;

    logic [RW-1:0] rem_a;
    logic [RW-1:0] rem_b;
    logic          c_in;
    logic          v_in;
    logic [W-1:0]  ch_s;
    logic          ch_c;
    logic          c_nx;
    logic [HI:0]   s_nx;
    logic [HI:0]   s_p;
    logic          c_p;
    logic          vld_p;

    if (k == 0) begin : g_src
      assign rem_a = a;
      assign rem_b = ext_b(b);
      assign c_in  = 1'b0;
      assign v_in  = in_valid;
      assign s_nx  = ch_s;
    end else begin : g_src
      assign rem_a = g_stage[k-1].g_skew.a_p;
      assign rem_b = g_stage[k-1].g_skew.b_p;
      assign c_in  = g_stage[k-1].c_p;
      assign v_in  = vld[k-1];
      assign s_nx  = {ch_s, g_stage[k-1].s_p};
    end

    adder_chunk #(.W(W)) u_chunk (
      .a    (rem_a[W-1:0]),
      .b    (rem_b[W-1:0]),
      .cin  (c_in),
      .s    (ch_s),
      .cout (ch_c)
    );

    if (k == LAST) begin : g_top
`ifdef PIPELINED_CUSTOM_ADDER_SIGNED_EN
      assign c_nx = rem_a[RW-1] ^ rem_b[RW-1] ^ ch_c;
`else
      assign c_nx = ch_c;
`endif
    end else begin : g_top
      assign c_nx = ch_c;
    end

    // Stage k register: finished low bits, carry (or sign at the top), and unconsumed operand bits.
    if (k < LAST) begin : g_skew
      logic [RW-W-1:0] a_p;
      logic [RW-W-1:0] b_p;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_p <= '0;
          b_p <= '0;
        end else if (load[k] && v_in) begin
          a_p <= rem_a[RW-1:W];
          b_p <= rem_b[RW-1:W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= 1'b0;
        s_p   <= '0;
        c_p   <= 1'b0;
      end else if (load[k]) begin
        vld_p <= v_in;
        if (v_in) begin
          s_p <= s_nx;
          c_p <= c_nx;
        end
      end
    end

    assign vld[k] = vld_p;
  end

  assign in_ready  = load[0];
  assign out_valid = vld[LAST];
  assign sum       = {g_stage[LAST].c_p, g_stage[LAST].s_p};

endmodule

// File: tb/tb_pipelined_custom_adder.sv
// Bench for pipelined_custom_adder: three instances (STAGES 3, 1, 5) against a queue-based sum model.
module tb_pipelined_custom_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv    [3];
  logic        ir    [3];
  logic        ov    [3];
  logic        ordy  [3];
  logic [40:0] a_s   [3];
  logic [20:0] b_s   [3];
  logic [41:0] sum_s [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [41:0] q     [3][$];
  bit          stall [3];
  logic [41:0] hold  [3];

  always #5 clk = ~clk;

  pipelined_custom_adder #(.WA(41), .WB(21), .STAGES(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum_s[0]));
  pipelined_custom_adder #(.WA(41), .WB(21), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum_s[1]));
  pipelined_custom_adder #(.WA(41), .WB(21), .STAGES(5)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]), .b(b_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum_s[2]));

  function automatic int st_of(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 1 : 5);
  endfunction

  function automatic logic [41:0] ref_sum(input logic [40:0] x, input logic [20:0] y);
    longint sx, sy;
`ifdef PIPELINED_CUSTOM_ADDER_SIGNED_EN
    sx = $signed(x);
    sy = $signed(y);
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    return 42'(sx + sy);
  endfunction

  function automatic logic [40:0] rnd_a();
    if ($urandom_range(0, 7) == 0) return '1;
    return 41'({$urandom(), $urandom()});
  endfunction

  function automatic logic [20:0] rnd_b();
    if ($urandom_range(0, 7) == 0) return '1;
    return 21'($urandom());
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: the model is "every accepted pair comes out once, in order, as ref_sum".
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        q[i].delete();
        stall[i] = 1'b0;
        chk("reset out_valid", ov[i], 0);
        chk("reset sum", sum_s[i], 0);
        chk("reset in_ready", ir[i], 1);
      end else begin
        if (stall[i]) begin
          chk("stall hold out_valid", ov[i], 1);
          chk("stall hold sum", sum_s[i], hold[i]);
        end
        chk("in_ready", ir[i], (q[i].size() == st_of(i) && !ordy[i]) ? 0 : 1);
        if (q[i].size() == 0) chk("spurious out_valid", ov[i], 0);
        else if (ov[i]) chk("sum in order", sum_s[i], q[i][0]);
        stall[i] = ov[i] && !ordy[i];
        hold[i]  = sum_s[i];
        if (ov[i] && ordy[i] && q[i].size() != 0) void'(q[i].pop_front());
        if (iv[i] && ir[i]) q[i].push_back(ref_sum(a_s[i], b_s[i]));
      end
    end
  end

  task automatic run_one(input int i, input logic [40:0] x, input logic [20:0] y,
                         input logic [41:0] exp, input string nm);
    int lat;
    ordy[i] = 1'b1;
    a_s[i]  = x;
    b_s[i]  = y;
    iv[i]   = 1'b1;
    #1;
    chk({nm, " in_ready"}, ir[i], 1);
    @(posedge clk); #1;
    iv[i]  = 1'b0;
    a_s[i] = '0;
    b_s[i] = '0;
    lat = 1;
    while (!ov[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, st_of(i));
    chk({nm, " sum"}, sum_s[i], exp);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int i, input int n, input bit stalls);
    int          sent;
    int          w;
    bit          took;
    logic [40:0] pa;
    logic [20:0] pb;
    sent = 0;
    pa = rnd_a();
    pb = rnd_b();
    while (sent < n) begin
      ordy[i] = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      iv[i]   = stalls ? ($urandom_range(0, 4) != 0) : 1'b1;
      a_s[i]  = iv[i] ? pa : rnd_a();
      b_s[i]  = iv[i] ? pb : rnd_b();
      @(negedge clk);
      took = iv[i] && ir[i];
      @(posedge clk); #1;
      if (took) begin
        sent++;
        pa = rnd_a();
        pb = rnd_b();
      end
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    w = 0;
    while (q[i].size() != 0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain all results", q[i].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
      a_s[i]  = '0;
      b_s[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
`ifdef PIPELINED_CUSTOM_ADDER_SIGNED_EN
      run_one(i, 41'h1FFFFFFFFFF, 21'h1FFFFF, 42'h3FFFFFFFFFE, "minus1 plus minus1");
      run_one(i, 41'h0FFFFFFFFFF, 21'h100000, 42'h0FFFFEFFFFF, "max plus most negative b");
`else
      run_one(i, 41'h1FFFFFFFFFF, 21'h1FFFFF, 42'h200001FFFFE, "all ones");
`endif
      run_one(i, 41'h0FFFFFFFFFF, 21'h000001, 42'h10000000000, "full ripple");
    end

    stream(0, 100, 1'b1);
    stream(1, 30, 1'b0);
    stream(2, 40, 1'b1);

    // Two sums in flight on a stalled pipe, then an asynchronous reset mid-cycle.
    ordy[0] = 1'b0;
    a_s[0] = 41'h12345678901; b_s[0] = 21'h0ABCDE; iv[0] = 1'b1;
    @(posedge clk); #1;
    a_s[0] = 41'h00000000042; b_s[0] = 21'h000001;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset out_valid", ov[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", ov[0], 0);
    chk("async reset sum", sum_s[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[0] = 1'b1;
    run_one(0, 41'h00000000010, 21'h000020, 42'h00000000030, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
